// File: rtl/fp_dec_formatter.sv
// fp_dec_formatter: turns {sign, integer, binary fraction, decimal exponent} into BCD display fields.
// Exponent via 9-step double dabble, fraction via repeated multiply-by-ten (truncating).
module fp_dec_formatter #(
  parameter int FRAC_DIGITS = 6
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       sign,
  input  logic [4:0]                 nguyen,
  input  logic [19:0]                le,
  input  logic [8:0]                 lt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sign,
  output logic [7:0]                 int_bcd,
  output logic [4*FRAC_DIGITS-1:0]   frac_bcd,
  output logic                       exp_neg,
  output logic [11:0]                exp_bcd
);
  typedef enum logic [1:0] {IDLE, EXP, FRAC, DONE} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic [8:0] r_mag, w_mag;
  logic [19:0] r_acc;
  logic [23:0] w_p;
  logic [10:0] w_adj;
  logic [3:0] w_tens, w_ones;
  logic r_sign, r_neg;
  logic [7:0] r_int;
  logic [11:0] r_exp;
  logic [4*FRAC_DIGITS-1:0] r_frac;
  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
  always_comb begin
    w_mag = lt[8] ? -lt : lt;
    w_tens = 4'(nguyen / 5'd10);
    w_ones = 4'(nguyen % 5'd10);
    // magnitude never exceeds 256, so the hundreds nibble never needs the +3 correction
    w_adj = {r_exp[10:8], adj3(r_exp[7:4]), adj3(r_exp[3:0])};
    w_p = 24'(r_acc) * 24'd10;
    w_next = (r_state == IDLE) ? (in_valid ? EXP : IDLE) :
             (r_state == EXP)  ? ((r_cnt == 4'd8) ? FRAC : EXP) :
             (r_state == FRAC) ? ((r_cnt == 4'(FRAC_DIGITS - 1)) ? DONE : FRAC) :
                                 (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sign <= 1'b0;
      r_neg <= 1'b0;
      r_mag <= '0;
      r_acc <= '0;
      r_int <= '0;
      r_exp <= '0;
      r_frac <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_sign <= sign;
      r_neg <= lt[8];
      r_mag <= w_mag;
      r_acc <= le;
      r_int <= {w_tens, w_ones};
      r_exp <= '0;
    end else if (r_state == EXP) begin
      r_exp <= {w_adj, r_mag[8]};
      r_mag <= r_mag << 1;
    end else if (r_state == FRAC) begin
      r_acc <= w_p[19:0];
      r_frac <= (r_frac << 4) | (4*FRAC_DIGITS)'(w_p[23:20]);
    end
  end
  assign in_ready = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_sign = r_sign;
  assign int_bcd = r_int;
  assign frac_bcd = r_frac;
  assign exp_neg = r_neg;
  assign exp_bcd = r_exp;
endmodule

// File: tb/tb_fp_dec_formatter.sv
// tb_fp_dec_formatter: directed scoreboard bench for fp_dec_formatter at FRAC_DIGITS=6.
module tb_fp_dec_formatter;
  logic CLK, RST, in_valid, in_ready, sign, out_valid, out_ready, out_sign, exp_neg;
  logic [4:0] nguyen;
  logic [19:0] le;
  logic [8:0] lt;
  logic [7:0] int_bcd;
  logic [23:0] frac_bcd;
  logic [11:0] exp_bcd;
  int passed = 0, failed = 0, total = 0;
  typedef struct {
    logic s;
    logic [7:0] ib;
    logic [23:0] fb;
    logic n;
    logic [11:0] eb;
  } exp_t;
  exp_t sb[$];
  fp_dec_formatter #(.FRAC_DIGITS(6)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .sign(sign),
    .nguyen(nguyen), .le(le), .lt(lt), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .int_bcd(int_bcd), .frac_bcd(frac_bcd), .exp_neg(exp_neg),
    .exp_bcd(exp_bcd)
  );
  initial CLK = 0;
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  function automatic exp_t mk(input logic s, input logic [7:0] ib, input logic [23:0] fb,
                              input logic n, input logic [11:0] eb);
    exp_t e;
    e.s = s; e.ib = ib; e.fb = fb; e.n = n; e.eb = eb;
    return e;
  endfunction
  // reference: truncated fraction digits from le*10^6/2^20, exponent digits by division
  function automatic exp_t model(input logic s, input logic [4:0] n, input logic [19:0] l,
                                 input logic [8:0] t);
    exp_t e;
    longint f;
    int m;
    e.s = s;
    e.ib = {4'(int'(n) / 10), 4'(int'(n) % 10)};
    f = (longint'(l) * 64'd1000000) >> 20;
    for (int i = 0; i < 6; i++) begin
      e.fb[4*i +: 4] = 4'(f % 10);
      f = f / 10;
    end
    m = t[8] ? 512 - int'(t) : int'(t);
    e.n = t[8];
    e.eb = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    return e;
  endfunction
  task automatic drive(input logic s, input logic [4:0] n, input logic [19:0] l, input logic [8:0] t);
    sign = s; nguyen = n; le = l; lt = t; in_valid = 1;
  endtask
  task automatic accept(input logic s, input logic [4:0] n, input logic [19:0] l,
                        input logic [8:0] t, input exp_t e);
    int k = 0;
    @(negedge CLK);
    drive(s, n, l, t);
    while (!in_ready && k < 50) begin
      @(negedge CLK);
      k++;
    end
    check("accept_ready", in_ready, 1);
    sb.push_back(e);
    @(negedge CLK);
    in_valid = 0;
  endtask
  task automatic wait_result();
    int k = 0;
    exp_t e;
    while (!out_valid && k < 40) begin
      @(negedge CLK);
      k++;
    end
    check("latency", k, 15);
    check("in_ready_in_done", in_ready, 0);
    if (sb.size() == 0) check("scoreboard_empty", 1, 0);
    else begin
      e = sb.pop_front();
      check("out_sign", out_sign, e.s);
      check("int_bcd", int_bcd, e.ib);
      check("frac_bcd", frac_bcd, e.fb);
      check("exp_neg", exp_neg, e.n);
      check("exp_bcd", exp_bcd, e.eb);
    end
  endtask
  task automatic release_out();
    out_ready = 1;
    @(negedge CLK);
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
    out_ready = 0;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_sign"}, out_sign, 0);
    check({tag, "_int"}, int_bcd, 0);
    check({tag, "_frac"}, frac_bcd, 0);
    check({tag, "_neg"}, exp_neg, 0);
    check({tag, "_exp"}, exp_bcd, 0);
  endtask
  initial begin
    RST = 1; in_valid = 0; out_ready = 0; sign = 0; nguyen = 0; le = 0; lt = 0;
    repeat (2) @(negedge CLK);
    RST = 0;
    check_zero("reset");
    accept(0, 5'd3, 20'h40000, 9'd0, mk(0, 8'h03, 24'h250000, 0, 12'h000));
    wait_result();
    release_out();
    accept(1, 5'd31, 20'hFFFFF, 9'h100, mk(1, 8'h31, 24'h999999, 1, 12'h256));
    wait_result();
    release_out();
    accept(0, 5'd10, 20'h80000, 9'd255, mk(0, 8'h10, 24'h500000, 0, 12'h255));
    wait_result();
    // new bundle offered while the result is held: must be ignored until release
    drive(0, 5'd0, 20'h0, 9'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("hold_valid", out_valid, 1);
      check("hold_frac", frac_bcd, 24'h500000);
      check("hold_int", int_bcd, 8'h10);
      check("hold_exp", exp_bcd, 12'h255);
    end
    out_ready = 1;
    @(negedge CLK);
    out_ready = 0;
    check("hold_idle", in_ready, 1);
    check("hold_int_kept", int_bcd, 8'h10);
    sb.push_back(model(0, 5'd0, 20'h0, 9'd0));
    @(negedge CLK);
    in_valid = 0;
    check("hold_accepted", in_ready, 0);
    wait_result();
    release_out();
    accept(0, 5'd7, 20'h12345, 9'd42, model(0, 5'd7, 20'h12345, 9'd42));
    repeat (6) @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    void'(sb.pop_back());
    check_zero("midreset");
    accept(0, 5'd5, 20'h19999, 9'h1FD, mk(0, 8'h05, 24'h099999, 1, 12'h003));
    wait_result();
    release_out();
    for (int i = 0; i < 4; i++) begin
      logic s;
      logic [4:0] n;
      logic [19:0] l;
      logic [8:0] t;
      s = 1'($urandom); n = 5'($urandom); l = 20'($urandom); t = 9'($urandom);
      accept(s, n, l, t, model(s, n, l, t));
      wait_result();
      release_out();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
